// File: rtl/spi_i2s_tx_fifo.sv
// Transmit FIFO (8x32) for the SPI/I2S shifter: MSB-aligns words on push, show-ahead head word.
// Latency: a push is visible on fill/head the next cycle; a pop presents the next word the next cycle.
// Backpressure: none. A push at full without a pop is dropped (ovr_err). A pop at empty is ignored (udr_err).
module spi_i2s_tx_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          i2s_clk_shft,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_dat,
    input  logic [1:0]    datlen,
    input  logic          tx_fifo_acq,
    input  logic [2:0]    txe_thr,
    input  logic          err_clr,
    output logic [DW-1:0] tx_fifo_dat,
    output logic [3:0]    tx_fifo_fill,
    output logic          tx_empty,
    output logic          tx_full,
    output logic          txe,
    output logic          ovr_err,
    output logic          udr_err
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    fill;
    logic [DW-1:0] wr_aligned;
    logic          push_ok;
    logic          pop_ok;
    logic          ovr_set;
    logic          udr_set;

    always_comb begin
        wr_aligned = wr_dat;
        case (datlen)
            2'b00:   wr_aligned = {wr_dat[15:0], 16'h0};
            2'b01:   wr_aligned = {wr_dat[23:0], 8'h0};
            default: wr_aligned = wr_dat;
        endcase
    end

    assign tx_empty     = (fill == 4'd0);
    assign tx_full      = (fill == 4'(DEPTH));
    assign txe          = (fill <= {1'b0, txe_thr});
    assign tx_fifo_fill = fill;
    assign tx_fifo_dat  = tx_empty ? '0 : mem[rd_ptr];

    // At full, a simultaneous pop frees the slot the push lands in.
    assign pop_ok  = tx_fifo_acq && !tx_empty;
    assign push_ok = wr_en && (!tx_full || tx_fifo_acq);
    assign ovr_set = !flush && wr_en && tx_full && !tx_fifo_acq;
    assign udr_set = !flush && tx_fifo_acq && tx_empty;

    always_ff @(posedge i2s_clk_shft) begin
        if (!rst && !flush && push_ok) begin
            mem[wr_ptr] <= wr_aligned;
        end
    end

    always_ff @(posedge i2s_clk_shft) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            ovr_err <= 1'b0;
            udr_err <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                fill   <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
                case ({push_ok, pop_ok})
                    2'b10:   fill <= fill + 4'd1;
                    2'b01:   fill <= fill - 4'd1;
                    default: fill <= fill;
                endcase
            end
            // A same-cycle set beats err_clr.
            if (ovr_set)      ovr_err <= 1'b1;
            else if (err_clr) ovr_err <= 1'b0;
            if (udr_set)      udr_err <= 1'b1;
            else if (err_clr) udr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_i2s_tx_fifo.sv
// Directed bench for spi_i2s_tx_fifo: alignment, full/overrun, underrun, wrap, threshold, flush and reset.
module tb_spi_i2s_tx_fifo;

    logic        i2s_clk_shft = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_dat = '0;
    logic [1:0]  datlen = 2'b10;
    logic        tx_fifo_acq = 1'b0;
    logic [2:0]  txe_thr = 3'd0;
    logic        err_clr = 1'b0;
    logic [31:0] tx_fifo_dat;
    logic [3:0]  tx_fifo_fill;
    logic        tx_empty, tx_full, txe, ovr_err, udr_err;

    int checks = 0;
    int errors = 0;

    spi_i2s_tx_fifo dut (
        .i2s_clk_shft(i2s_clk_shft), .rst(rst), .flush(flush), .wr_en(wr_en),
        .wr_dat(wr_dat), .datlen(datlen), .tx_fifo_acq(tx_fifo_acq), .txe_thr(txe_thr),
        .err_clr(err_clr), .tx_fifo_dat(tx_fifo_dat), .tx_fifo_fill(tx_fifo_fill),
        .tx_empty(tx_empty), .tx_full(tx_full), .txe(txe), .ovr_err(ovr_err), .udr_err(udr_err)
    );

    always #5 i2s_clk_shft = ~i2s_clk_shft;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
        $fatal(1);
    end

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge i2s_clk_shft);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; tx_fifo_acq = 0; flush = 0; err_clr = 0; rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; step(); step();
        rst = 0; txe_thr = 3'd0; step();
        checks++; if (tx_fifo_fill !== 4'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", tx_fifo_fill); end
        checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", tx_empty); end
        checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", tx_full); end
        checks++; if (txe !== 1'b1) begin errors++; $display("FAIL reset_txe got %b exp 1", txe); end
        checks++; if (tx_fifo_dat !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 0", tx_fifo_dat); end
        checks++; if (ovr_err !== 1'b0 || udr_err !== 1'b0) begin errors++; $display("FAIL reset_err got ovr=%b udr=%b exp 0 0", ovr_err, udr_err); end
    endtask

    task automatic test_align();
        logic [31:0] expd [3];
        expd[0] = 32'h1234_0000; expd[1] = 32'h1234_5600; expd[2] = 32'hDEAD_BEEF;
        wr_en = 1;
        datlen = 2'b00; wr_dat = 32'hABCD_1234; step();
        datlen = 2'b01; wr_dat = 32'h0012_3456; step();
        datlen = 2'b10; wr_dat = 32'hDEAD_BEEF; step();
        wr_en = 0;
        checks++; if (tx_fifo_fill !== 4'd3) begin errors++; $display("FAIL align_fill3 got %0d exp 3", tx_fifo_fill); end
        tx_fifo_acq = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (tx_fifo_dat !== expd[i]) begin errors++; $display("FAIL align_word%0d got %h exp %h", i, tx_fifo_dat, expd[i]); end
            step();
            checks++; if (tx_fifo_fill !== 4'(2 - i)) begin errors++; $display("FAIL align_fill_after_pop%0d got %0d exp %0d", i, tx_fifo_fill, 2 - i); end
        end
        tx_fifo_acq = 0;
        checks++; if (tx_empty !== 1'b1 || udr_err !== 1'b0) begin errors++; $display("FAIL align_end got empty=%b udr=%b exp 1 0", tx_empty, udr_err); end
    endtask

    task automatic test_full();
        logic [31:0] expd [8];
        for (int i = 0; i < 7; i++) expd[i] = 32'(i + 2);
        expd[7] = 32'd10;
        datlen = 2'b10; wr_en = 1;
        for (int i = 1; i <= 8; i++) begin wr_dat = 32'(i); step(); end
        checks++; if (tx_full !== 1'b1 || tx_fifo_fill !== 4'd8) begin errors++; $display("FAIL full_flag got full=%b fill=%0d exp 1 8", tx_full, tx_fifo_fill); end
        checks++; if (txe !== 1'b0) begin errors++; $display("FAIL full_txe got %b exp 0", txe); end
        wr_dat = 32'd9; step();
        checks++; if (ovr_err !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", ovr_err); end
        checks++; if (tx_fifo_fill !== 4'd8 || tx_fifo_dat !== 32'd1) begin errors++; $display("FAIL ovr_nochange got fill=%0d head=%h exp 8 1", tx_fifo_fill, tx_fifo_dat); end
        wr_dat = 32'd10; tx_fifo_acq = 1; step();
        wr_en = 0; tx_fifo_acq = 0;
        checks++; if (tx_fifo_fill !== 4'd8 || tx_fifo_dat !== 32'd2) begin errors++; $display("FAIL pushpop_full got fill=%0d head=%h exp 8 2", tx_fifo_fill, tx_fifo_dat); end
        err_clr = 1; step(); err_clr = 0;
        checks++; if (ovr_err !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", ovr_err); end
        tx_fifo_acq = 1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx_fifo_dat !== expd[i]) begin errors++; $display("FAIL full_drain%0d got %h exp %h", i, tx_fifo_dat, expd[i]); end
            step();
        end
        tx_fifo_acq = 0;
        checks++; if (tx_fifo_fill !== 4'd0 || udr_err !== 1'b0) begin errors++; $display("FAIL full_drained got fill=%0d udr=%b exp 0 0", tx_fifo_fill, udr_err); end
    endtask

    task automatic test_underrun();
        wr_en = 1; wr_dat = 32'h55; tx_fifo_acq = 1; step();
        wr_en = 0;
        checks++; if (udr_err !== 1'b1) begin errors++; $display("FAIL udr_set got %b exp 1", udr_err); end
        checks++; if (tx_fifo_fill !== 4'd1 || tx_fifo_dat !== 32'h55) begin errors++; $display("FAIL udr_push got fill=%0d head=%h exp 1 55", tx_fifo_fill, tx_fifo_dat); end
        step();
        checks++; if (tx_fifo_fill !== 4'd0) begin errors++; $display("FAIL udr_drain got %0d exp 0", tx_fifo_fill); end
        err_clr = 1; step();
        checks++; if (udr_err !== 1'b1) begin errors++; $display("FAIL udr_set_wins got %b exp 1", udr_err); end
        tx_fifo_acq = 0; step(); err_clr = 0;
        checks++; if (udr_err !== 1'b0) begin errors++; $display("FAIL udr_clr got %b exp 0", udr_err); end
    endtask

    task automatic test_back_to_back();
        wr_en = 1; wr_dat = 32'd1; step();
        tx_fifo_acq = 1;
        for (int k = 1; k <= 11; k++) begin
            wr_dat = 32'(k + 1);
            checks++; if (tx_fifo_dat !== 32'(k)) begin errors++; $display("FAIL wrap_word%0d got %h exp %h", k, tx_fifo_dat, k); end
            step();
            checks++; if (tx_fifo_fill !== 4'd1) begin errors++; $display("FAIL wrap_fill%0d got %0d exp 1", k, tx_fifo_fill); end
        end
        wr_en = 0;
        checks++; if (tx_fifo_dat !== 32'd12) begin errors++; $display("FAIL wrap_word12 got %h exp c", tx_fifo_dat); end
        step(); tx_fifo_acq = 0;
        checks++; if (tx_fifo_fill !== 4'd0 || udr_err !== 1'b0 || ovr_err !== 1'b0) begin errors++; $display("FAIL wrap_end got fill=%0d udr=%b ovr=%b exp 0 0 0", tx_fifo_fill, udr_err, ovr_err); end
    endtask

    task automatic test_txe_flush_rst();
        txe_thr = 3'd3; step();
        checks++; if (txe !== 1'b1) begin errors++; $display("FAIL txe_fill0 got %b exp 1", txe); end
        wr_en = 1;
        for (int i = 1; i <= 8; i++) begin
            wr_dat = 32'(i); step();
            checks++; if (txe !== (i <= 3)) begin errors++; $display("FAIL txe_fill%0d got %b exp %b", i, txe, (i <= 3)); end
        end
        wr_en = 0; tx_fifo_acq = 1; step(); step(); step(); tx_fifo_acq = 0;
        checks++; if (tx_fifo_fill !== 4'd5 || tx_fifo_dat !== 32'd4) begin errors++; $display("FAIL pre_flush got fill=%0d head=%h exp 5 4", tx_fifo_fill, tx_fifo_dat); end
        flush = 1; wr_en = 1; wr_dat = 32'hF0; step(); flush = 0; wr_en = 0;
        checks++; if (tx_fifo_fill !== 4'd0 || txe !== 1'b1 || tx_empty !== 1'b1 || tx_fifo_dat !== 32'h0) begin errors++; $display("FAIL flush got fill=%0d txe=%b empty=%b dat=%h exp 0 1 1 0", tx_fifo_fill, txe, tx_empty, tx_fifo_dat); end
        wr_en = 1;
        for (int i = 0; i < 6; i++) begin wr_dat = 32'(i + 32'hA0); step(); end
        wr_en = 0;
        checks++; if (tx_fifo_fill !== 4'd6 || tx_fifo_dat !== 32'hA0) begin errors++; $display("FAIL pre_rst got fill=%0d head=%h exp 6 a0", tx_fifo_fill, tx_fifo_dat); end
        tx_fifo_acq = 1; step(); tx_fifo_acq = 0; step();
        tx_fifo_acq = 0;
        rst = 1; step(); rst = 0;
        checks++; if (tx_fifo_fill !== 4'd0 || tx_empty !== 1'b1 || tx_full !== 1'b0 || txe !== 1'b1) begin errors++; $display("FAIL rst_mid_flags got fill=%0d empty=%b full=%b txe=%b exp 0 1 0 1", tx_fifo_fill, tx_empty, tx_full, txe); end
        checks++; if (tx_fifo_dat !== 32'h0 || ovr_err !== 1'b0 || udr_err !== 1'b0) begin errors++; $display("FAIL rst_mid_dat got dat=%h ovr=%b udr=%b exp 0 0 0", tx_fifo_dat, ovr_err, udr_err); end
        tx_fifo_acq = 1; step(); tx_fifo_acq = 0;
        checks++; if (udr_err !== 1'b1) begin errors++; $display("FAIL rst_then_pop_udr got %b exp 1", udr_err); end
    endtask

    initial begin
        #1;
        test_reset();
        idle(); test_align();
        idle(); test_full();
        idle(); test_underrun();
        idle(); test_back_to_back();
        idle(); test_txe_flush_rst();
        idle(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
